// File: rtl/timer_scheduler.sv
// Four-channel tick timer: free-running prescaler, per-channel one-shot/periodic
// countdown, and one registered event slot fed round-robin with overrun flags.

module timer_channel #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_tick,
    input  logic          i_cfg_hit,
    input  logic          i_cfg_arm,
    input  logic          i_cfg_periodic,
    input  logic [CW-1:0] i_cfg_load,
    input  logic          i_clr,
    output logic          o_run,
    output logic          o_pend,
    output logic          o_ovr
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, r_reload, w_cnt_nx, w_reload_nx;
    logic          r_periodic, w_periodic_nx;
    logic          r_pend, r_ovr;
    logic          w_expire;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_pend     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_reload   <= w_reload_nx;
            r_periodic <= w_periodic_nx;
            // a fresh expiry beats a same-edge clear from the event slot
            r_pend     <= w_expire | (r_pend & ~i_clr);
            r_ovr      <= (w_expire & r_pend) | (r_ovr & ~i_clr);
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_reload_nx   = r_reload;
        w_periodic_nx = r_periodic;
        w_expire      = 1'b0;
        if (i_cfg_hit) begin
            // any command to this channel swallows a coincident tick
            if (!i_cfg_arm) begin
                w_state_nx = ST_IDLE;
            end else if (i_cfg_load != '0) begin
                w_state_nx    = ST_RUN;
                w_cnt_nx      = i_cfg_load;
                w_reload_nx   = i_cfg_load;
                w_periodic_nx = i_cfg_periodic;
            end
        end else if (i_tick && r_state == ST_RUN) begin
            if (r_cnt == CW'(1)) begin
                w_expire = 1'b1;
                if (r_periodic) w_cnt_nx = r_reload;
                else            w_state_nx = ST_IDLE;
            end else begin
                w_cnt_nx = r_cnt - 1'b1;
            end
        end
    end

    assign o_run  = (r_state == ST_RUN);
    assign o_pend = r_pend;
    assign o_ovr  = r_ovr;
endmodule

module timer_scheduler #(
    parameter int PRESCALE = 999,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_cfg_valid,
    input  logic [1:0]    i_cfg_ch,
    input  logic          i_cfg_arm,
    input  logic          i_cfg_periodic,
    input  logic [CW-1:0] i_cfg_load,
    output logic          o_tick_out,
    output logic          o_evt_valid,
    output logic [1:0]    o_evt_ch,
    output logic          o_evt_ovr,
    input  logic          i_evt_ready,
    output logic [3:0]    o_active
);
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [3:0]    w_hit, w_run, w_pend, w_ovr, w_clr;
    logic [1:0]    w_sel, w_idx, r_last_grant, r_evt_ch;
    logic          w_found, w_load, r_evt_valid, r_evt_ovr;

    assign w_tick = (r_presc == PW'(PRESCALE));

    always_ff @(posedge clk) begin
        if (!resetn)     r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign w_hit[g] = i_cfg_valid && (i_cfg_ch == 2'(g));
        timer_channel #(.CW(CW)) u_ch (
            .clk            (clk),
            .resetn         (resetn),
            .i_tick         (w_tick),
            .i_cfg_hit      (w_hit[g]),
            .i_cfg_arm      (i_cfg_arm),
            .i_cfg_periodic (i_cfg_periodic),
            .i_cfg_load     (i_cfg_load),
            .i_clr          (w_clr[g]),
            .o_run          (w_run[g]),
            .o_pend         (w_pend[g]),
            .o_ovr          (w_ovr[g])
        );
    end

    // round-robin: first pending channel after the last one granted
    always_comb begin
        w_sel   = r_last_grant;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && w_pend[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_load = (!r_evt_valid || i_evt_ready) && w_found;
    assign w_clr  = w_load ? (4'b0001 << w_sel) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_evt_valid  <= 1'b0;
            r_evt_ch     <= 2'd0;
            r_evt_ovr    <= 1'b0;
            r_last_grant <= 2'd3;
        end else if (w_load) begin
            r_evt_valid  <= 1'b1;
            r_evt_ch     <= w_sel;
            r_evt_ovr    <= w_ovr[w_sel];
            r_last_grant <= w_sel;
        end else if (i_evt_ready) begin
            r_evt_valid  <= 1'b0;
        end
    end

    assign o_tick_out  = w_tick;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_ovr   = r_evt_ovr;
    assign o_active    = w_run;
endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: reset/table/directed sequences plus random traffic
// checked every cycle against a tick-level reference model.

module tb_timer_scheduler;
    localparam int P  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_ch = 2'd0;
    logic          cfg_arm = 1'b0;
    logic          cfg_periodic = 1'b0;
    logic [CW-1:0] cfg_load = '0;
    logic          evt_ready = 1'b0;
    logic          tick_out, evt_valid, evt_ovr;
    logic [1:0]    evt_ch;
    logic [3:0]    active;

    int n_chk = 0;
    int n_fail = 0;
    int t_rel = 0;

    always #5 clk = ~clk;

    timer_scheduler #(.PRESCALE(P), .CW(CW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_cfg_valid    (cfg_valid),
        .i_cfg_ch       (cfg_ch),
        .i_cfg_arm      (cfg_arm),
        .i_cfg_periodic (cfg_periodic),
        .i_cfg_load     (cfg_load),
        .o_tick_out     (tick_out),
        .o_evt_valid    (evt_valid),
        .o_evt_ch       (evt_ch),
        .o_evt_ovr      (evt_ovr),
        .i_evt_ready    (evt_ready),
        .o_active       (active)
    );

    // reference model: ticks counted from reset, remaining ticks per channel
    bit m_known = 0;
    int m_t;
    bit m_run[4];
    int m_left[4];
    int m_rel[4];
    bit m_per[4], m_pend[4], m_ovr[4];
    bit m_ev_v, m_ev_ovr;
    int m_ev_ch, m_last;

    typedef struct { int t; int ch; int ovr; } ev_t;
    ev_t evq[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t_rel);
        end
    endtask

    task automatic model_reset();
        m_known = 1;
        m_t = 0;
        for (int c = 0; c < 4; c++) begin
            m_run[c] = 0; m_left[c] = 0; m_rel[c] = 0;
            m_per[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
        m_ev_v = 0; m_ev_ch = 0; m_ev_ovr = 0; m_last = 3;
    endtask

    task automatic model_next();
        bit tick, ld, hit;
        bit ex[4];
        int sel;
        if (!resetn) begin
            model_reset();
            return;
        end
        tick = (m_t % (P + 1)) == P;
        sel = -1;
        for (int k = 1; k <= 4; k++)
            if (sel < 0 && m_pend[(m_last + k) % 4]) sel = (m_last + k) % 4;
        ld = (!m_ev_v || evt_ready) && sel >= 0;
        for (int c = 0; c < 4; c++) begin
            hit = cfg_valid && (int'(cfg_ch) == c);
            ex[c] = tick && m_run[c] && m_left[c] == 1 && !hit;
        end
        if (ld) begin
            m_ev_v = 1; m_ev_ch = sel; m_ev_ovr = m_ovr[sel]; m_last = sel;
        end else if (evt_ready) begin
            m_ev_v = 0;
        end
        for (int c = 0; c < 4; c++) begin
            hit = cfg_valid && (int'(cfg_ch) == c);
            if (ex[c]) begin
                if (m_pend[c]) m_ovr[c] = 1;
                m_pend[c] = 1;
            end else if (ld && sel == c) begin
                m_pend[c] = 0;
                m_ovr[c] = 0;
            end
            if (hit) begin
                if (!cfg_arm) m_run[c] = 0;
                else if (cfg_load != 0) begin
                    m_run[c] = 1; m_left[c] = int'(cfg_load);
                    m_rel[c] = int'(cfg_load); m_per[c] = cfg_periodic;
                end
            end else if (tick && m_run[c]) begin
                if (m_left[c] == 1) begin
                    if (m_per[c]) m_left[c] = m_rel[c];
                    else          m_run[c] = 0;
                end else begin
                    m_left[c] = m_left[c] - 1;
                end
            end
        end
        m_t++;
    endtask

    task automatic cyc();
        int act;
        @(negedge clk);
        if (m_known) begin
            act = 0;
            for (int c = 0; c < 4; c++) if (m_run[c]) act |= (1 << c);
            check("m_tick", int'(tick_out), int'((m_t % (P + 1)) == P));
            check("m_evt_valid", int'(evt_valid), int'(m_ev_v));
            if (m_ev_v) begin
                check("m_evt_ch", int'(evt_ch), m_ev_ch);
                check("m_evt_ovr", int'(evt_ovr), int'(m_ev_ovr));
            end
            check("m_active", int'(active), act);
        end
        if (evt_valid && evt_ready) evq.push_back('{t_rel, int'(evt_ch), int'(evt_ovr)});
        model_next();
        @(posedge clk);
        #1;
        t_rel++;
    endtask

    task automatic do_reset();
        resetn = 0; cfg_valid = 0; evt_ready = 0;
        cyc(); cyc();
        resetn = 1;
        t_rel = 0;
        evq.delete();
    endtask

    task automatic cfg1(input int ch, input int arm, input int per, input int load);
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_arm = 1'(arm);
        cfg_periodic = 1'(per); cfg_load = CW'(load);
        cyc();
        cfg_valid = 0;
    endtask

    task automatic run_to(input int n);
        while (t_rel < n) cyc();
    endtask

    typedef struct {
        bit cv; int ch; bit arm; bit per; int load;
        bit e_tick; bit e_v; int e_ch; int e_act;
    } vec_t;
    vec_t tbl[20];

    initial begin
        // four one-shots expiring on one tick, then a two-channel round
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 1, 0, 0, 0, 1};
        tbl[5]  = '{1, 2, 1, 0, 1, 0, 0, 0, 3};
        tbl[6]  = '{1, 3, 1, 0, 1, 0, 0, 0, 7};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 15};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 2, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 3, 0};
        tbl[13] = '{1, 2, 1, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 1, 0, 1, 0, 0, 0, 4};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 5};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 1, 2, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

        do_reset();
        check("rst_tick", int'(tick_out), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_ch", int'(evt_ch), 0);
        check("rst_ovr", int'(evt_ovr), 0);
        check("rst_active", int'(active), 0);

        evt_ready = 1;
        foreach (tbl[i]) begin
            cfg_valid = tbl[i].cv; cfg_ch = 2'(tbl[i].ch); cfg_arm = tbl[i].arm;
            cfg_periodic = tbl[i].per; cfg_load = CW'(tbl[i].load);
            check($sformatf("tbl%0d_tick", i), int'(tick_out), int'(tbl[i].e_tick));
            check($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                check($sformatf("tbl%0d_ch", i), int'(evt_ch), tbl[i].e_ch);
                check($sformatf("tbl%0d_ovr", i), int'(evt_ovr), 0);
            end
            check($sformatf("tbl%0d_active", i), int'(active), tbl[i].e_act);
            cyc();
        end
        cfg_valid = 0;

        // one-shot ch1, load 3
        do_reset();
        evt_ready = 1;
        cfg1(1, 1, 0, 3);
        run_to(11);
        check("os_active_before", int'(active[1]), 1);
        cyc();
        check("os_active_after", int'(active[1]), 0);
        run_to(40);
        check("os_count", evq.size(), 1);
        if (evq.size() > 0) begin
            check("os_time", evq[0].t, 13);
            check("os_ch", evq[0].ch, 1);
            check("os_ovr", evq[0].ovr, 0);
        end

        // periodic ch0, load 2, then disarm
        do_reset();
        evt_ready = 1;
        cfg1(0, 1, 1, 2);
        run_to(28);
        cfg1(0, 0, 0, 0);
        run_to(50);
        check("per_count", evq.size(), 3);
        if (evq.size() == 3) begin
            check("per_first", evq[0].t, 9);
            check("per_gap1", evq[1].t - evq[0].t, 8);
            check("per_gap2", evq[2].t - evq[1].t, 8);
            check("per_ch", evq[2].ch, 0);
        end
        check("per_active", int'(active[0]), 0);

        // backpressure and overrun on ch2
        do_reset();
        cfg1(2, 1, 1, 1);
        run_to(5);
        for (int i = 0; i < 12; i++) begin
            check("hold_valid", int'(evt_valid), 1);
            check("hold_ch", int'(evt_ch), 2);
            check("hold_ovr", int'(evt_ovr), 0);
            cyc();
        end
        evt_ready = 1;
        cyc();
        check("ovr_valid", int'(evt_valid), 1);
        check("ovr_ch", int'(evt_ch), 2);
        check("ovr_ovr", int'(evt_ovr), 1);
        cfg1(2, 0, 0, 0);
        run_to(30);

        // arm on a tick cycle, then reset mid-count
        do_reset();
        evt_ready = 1;
        run_to(3);
        check("armtick_tick", int'(tick_out), 1);
        cfg1(3, 1, 0, 2);
        check("armtick_active", int'(active), 8);
        run_to(14);
        check("armtick_count", evq.size(), 1);
        if (evq.size() > 0) begin
            check("armtick_time", evq[0].t, 13);
            check("armtick_ch", evq[0].ch, 3);
        end
        cfg1(1, 1, 0, 5);
        run_to(20);
        check("mid_active", int'(active), 2);
        resetn = 0;
        cyc(); cyc();
        resetn = 1;
        evq.delete();
        for (int i = 0; i < 40; i++) begin
            check("post_rst_active", int'(active), 0);
            cyc();
        end
        check("post_rst_events", evq.size(), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_arm      = ($urandom_range(0, 3) != 0);
            cfg_periodic = 1'($urandom_range(0, 1));
            cfg_load     = CW'($urandom_range(0, 5));
            evt_ready    = ($urandom_range(0, 2) != 0);
            resetn       = ($urandom_range(0, 499) != 0);
            cyc();
        end
        resetn = 1;
        cfg_valid = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
